// File: rtl/cfg_ram_ctrl_pkg.sv
// Shared types, constants and select helpers for the cfg_ram bank controller.
package cfg_ram_ctrl_pkg;

  localparam int SEL_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } host_state_e;

  // Slice idx of ram_dout_bus belongs to the RAM addressed by sel.
  function automatic logic slice_hit(input logic [SEL_WIDTH-1:0] sel, input int idx);
    return (int'(sel) == idx);
  endfunction

  function automatic logic sel_in_range(input logic [SEL_WIDTH-1:0] sel, input int num_ram);
    return (int'(sel) < num_ram);
  endfunction

endpackage

// File: rtl/cfg_ram_arb.sv
// Grant logic for the shared RAM port: lookups win unless the host has starved too long.
module cfg_ram_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic lk_valid,
  input  logic cfg_valid,
  input  logic host_idle,
  output logic grant_lk,
  output logic grant_cfg,
  output logic force_grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             force_s;

  assign force_s     = (cnt_q == CNT_W'(STARVE_LIMIT)) & cfg_valid & host_idle;
  assign grant_lk    = lk_valid & ~force_s;
  assign grant_cfg   = cfg_valid & host_idle & (~lk_valid | force_s);
  assign force_grant = force_s;

  // Count consecutive idle cycles in which a pending host request lost to a lookup.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_cfg || !cfg_valid) begin
      cnt_d = '0;
    end else if (host_idle && lk_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cfg_ram_ctrl.sv
// Shares the cfg_ram bank address port between parser lookups and host config
// writes/readbacks; owns the readback FSM and response registers.
module cfg_ram_ctrl
  import cfg_ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RAM      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lk_valid,
  output logic                          lk_ready,
  input  logic [SEL_WIDTH-1:0]          lk_sel,
  input  logic [ADDR_WIDTH-1:0]         lk_addr,
  output logic                          lk_rvalid,
  output logic [DATA_WIDTH-1:0]         lk_rdata,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic                          cfg_we,
  input  logic [SEL_WIDTH-1:0]          cfg_sel,
  input  logic [ADDR_WIDTH-1:0]         cfg_addr,
  input  logic [DATA_WIDTH-1:0]         cfg_wdata,
  output logic                          cfg_rvalid,
  input  logic                          cfg_rready,
  output logic [DATA_WIDTH-1:0]         cfg_rdata,
  output logic                          cfg_err,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [SEL_WIDTH-1:0]          ram_sel,
  output logic                          ram_wr_en,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [NUM_RAM*DATA_WIDTH-1:0] ram_dout_bus
);

  host_state_e           state_q;
  host_state_e           state_d;
  logic                  grant_lk_s;
  logic                  grant_cfg_s;
  logic                  force_s;
  logic                  host_idle_s;
  logic                  cfg_rvalid_s;
  logic                  cfg_sel_ok_s;
  logic                  lk_rvalid_q;
  logic [SEL_WIDTH-1:0]  lk_sel_q;
  logic [SEL_WIDTH-1:0]  cfg_sel_q;
  logic [DATA_WIDTH-1:0] cfg_rdata_q;
  logic                  cfg_err_q;
  logic [DATA_WIDTH-1:0] lk_rdata_s;
  logic [DATA_WIDTH-1:0] cfg_slice_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [SEL_WIDTH-1:0]  ram_sel_s;
  logic [DATA_WIDTH-1:0] ram_din_s;
  logic                  ram_wr_en_s;

  assign cfg_sel_ok_s = sel_in_range(cfg_sel, NUM_RAM);

  cfg_ram_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .lk_valid   (lk_valid),
    .cfg_valid  (cfg_valid),
    .host_idle  (host_idle_s),
    .grant_lk   (grant_lk_s),
    .grant_cfg  (grant_cfg_s),
    .force_grant(force_s)
  );

  // Drive the shared bus from whichever request holds the grant this cycle.
  always_comb begin
    ram_addr_s  = '0;
    ram_sel_s   = '0;
    ram_din_s   = '0;
    ram_wr_en_s = 1'b0;
    if (grant_lk_s) begin
      ram_addr_s = lk_addr;
      ram_sel_s  = lk_sel;
    end else if (grant_cfg_s) begin
      ram_addr_s  = cfg_addr;
      ram_sel_s   = cfg_sel;
      ram_din_s   = cfg_wdata;
      ram_wr_en_s = cfg_we & cfg_sel_ok_s;
    end else begin
      ram_addr_s  = '0;
      ram_sel_s   = '0;
      ram_din_s   = '0;
      ram_wr_en_s = 1'b0;
    end
  end

  // Out-of-range selects hit no slice and therefore read as zero.
  always_comb begin
    lk_rdata_s  = '0;
    cfg_slice_s = '0;
    for (int i = 0; i < NUM_RAM; i++) begin
      lk_rdata_s  = lk_rdata_s  | ({DATA_WIDTH{slice_hit(lk_sel_q, i)}}  & ram_dout_bus[i*DATA_WIDTH +: DATA_WIDTH]);
      cfg_slice_s = cfg_slice_s | ({DATA_WIDTH{slice_hit(cfg_sel_q, i)}} & ram_dout_bus[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_cfg_s && !cfg_we && cfg_sel_ok_s) begin
          state_d = ST_RD_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: state_d = ST_RSP;
      ST_RSP: begin
        if (cfg_rready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    host_idle_s  = 1'b0;
    cfg_rvalid_s = 1'b0;
    case (state_q)
      ST_IDLE: host_idle_s  = 1'b1;
      ST_RSP:  cfg_rvalid_s = 1'b1;
      default: begin
        host_idle_s  = 1'b0;
        cfg_rvalid_s = 1'b0;
      end
    endcase
  end

  // Lookup data always follows its grant by exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_rvalid_q <= 1'b0;
      lk_sel_q    <= '0;
    end else begin
      lk_rvalid_q <= grant_lk_s;
      if (grant_lk_s) begin
        lk_sel_q <= lk_sel;
      end
    end
  end

  // The RAM output still reflects the host read during RD_WAIT, even if a lookup is issued then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_sel_q   <= '0;
      cfg_rdata_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= grant_cfg_s & ~cfg_sel_ok_s;
      if (grant_cfg_s) begin
        cfg_sel_q <= cfg_sel;
      end
      if (state_q == ST_RD_WAIT) begin
        cfg_rdata_q <= cfg_slice_s;
      end
    end
  end

  assign lk_ready   = ~force_s;
  assign cfg_ready  = host_idle_s & (~lk_valid | force_s);
  assign lk_rvalid  = lk_rvalid_q;
  assign lk_rdata   = lk_rdata_s;
  assign cfg_rvalid = cfg_rvalid_s;
  assign cfg_rdata  = cfg_rdata_q;
  assign cfg_err    = cfg_err_q;
  assign ram_addr   = ram_addr_s;
  assign ram_sel    = ram_sel_s;
  assign ram_wr_en  = ram_wr_en_s;
  assign ram_din    = ram_din_s;

endmodule

// File: tb/tb_cfg_ram_ctrl.sv
// Scoreboard bench for cfg_ram_ctrl with a behavioural read-first cfg_ram bank.
module tb_cfg_ram_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          lk_valid = 1'b0;
  logic          lk_ready;
  logic [7:0]    lk_sel = 8'd0;
  logic [AW-1:0] lk_addr = '0;
  logic          lk_rvalid;
  logic [DW-1:0] lk_rdata;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          cfg_we = 1'b0;
  logic [7:0]    cfg_sel = 8'd0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_rvalid;
  logic          cfg_rready = 1'b1;
  logic [DW-1:0] cfg_rdata;
  logic          cfg_err;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_sel;
  logic          ram_wr_en;
  logic [DW-1:0] ram_din;
  logic [NR*DW-1:0] ram_dout_bus;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        lk_q[$];
  exp_t        cfg_q[$];
  int          err_q[$];
  logic [31:0] wmem[int];
  logic [31:0] shadow[int];
  logic [31:0] dout[NR];

  cfg_ram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RAM(NR), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_sel(lk_sel), .lk_addr(lk_addr),
    .lk_rvalid(lk_rvalid), .lk_rdata(lk_rdata),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rvalid(cfg_rvalid), .cfg_rready(cfg_rready),
    .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_wr_en(ram_wr_en), .ram_din(ram_din),
    .ram_dout_bus(ram_dout_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int s, input int a);
    return 32'hC0DE_0000 | 32'(s << 8) | 32'(a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] s, input logic [AW-1:0] a);
    int k;
    k = int'(s) * 16 + int'(a);
    if (int'(s) >= NR) return 32'h0;
    return shadow.exists(k) ? shadow[k] : init_val(int'(s), int'(a));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Behavioural read-first RAM bank; unwritten words hold init_val.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NR; i++) begin
      if (int'(ram_sel) == i) begin
        dout[i] <= wmem.exists(i*16 + int'(ram_addr)) ? wmem[i*16 + int'(ram_addr)]
                                                       : init_val(i, int'(ram_addr));
        if (ram_wr_en) wmem[i*16 + int'(ram_addr)] = ram_din;
      end
    end
  end

  assign ram_dout_bus = {dout[3], dout[2], dout[1], dout[0]};

  // Issue side: record the expected response of every accepted request.
  always @(negedge clk) begin
    if (rst) begin
      if (lk_valid && lk_ready) lk_q.push_back('{data: exp_rd(lk_sel, lk_addr), cyc: cyc});
      if (cfg_valid && cfg_ready) begin
        if (int'(cfg_sel) >= NR) err_q.push_back(cyc);
        else if (cfg_we) shadow[int'(cfg_sel) * 16 + int'(cfg_addr)] = cfg_wdata;
        else cfg_q.push_back('{data: exp_rd(cfg_sel, cfg_addr), cyc: cyc});
      end
    end
  end

  // Monitor: compare every DUT response against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (rst) begin
      if (lk_rvalid) begin
        if (lk_q.size() == 0) check1("lk_unexpected_rvalid", lk_rvalid, 1'b0);
        else begin
          e = lk_q.pop_front();
          check("lk_rdata", lk_rdata, e.data);
          check("lk_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
      if (lk_q.size() > 0 && lk_q[0].cyc + 1 < cyc) begin
        check1("lk_missing_rvalid", lk_rvalid, 1'b1);
        void'(lk_q.pop_front());
      end
      if (cfg_rvalid && cfg_q.size() == 0) check1("cfg_unexpected_rvalid", cfg_rvalid, 1'b0);
      else if (cfg_rvalid && cfg_rready) begin
        e = cfg_q.pop_front();
        check("cfg_rdata", cfg_rdata, e.data);
        check1("cfg_latency", cyc >= e.cyc + 2, 1'b1);
      end
      if (!cfg_rvalid && cfg_q.size() > 0 && cfg_q[0].cyc + 2 < cyc) begin
        check1("cfg_missing_rvalid", cfg_rvalid, 1'b1);
        void'(cfg_q.pop_front());
      end
      if (cfg_err) begin
        if (err_q.size() == 0) check1("cfg_unexpected_err", cfg_err, 1'b0);
        else begin
          ec = err_q.pop_front();
          check("cfg_err_latency", 32'(cyc), 32'(ec + 1));
        end
      end
      if (err_q.size() > 0 && err_q[0] + 1 < cyc) begin
        check1("cfg_missing_err", cfg_err, 1'b1);
        void'(err_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check1("rst_lk_rvalid", lk_rvalid, 1'b0);
    check1("rst_cfg_rvalid", cfg_rvalid, 1'b0);
    check("rst_cfg_rdata", cfg_rdata, 32'h0);
    check1("rst_cfg_err", cfg_err, 1'b0);
    check1("rst_cfg_ready", cfg_ready, 1'b1);
    rst = 1'b1;
    nxt();

    // Host write then readback, no lookups.
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_sel = 8'd2; cfg_addr = 4'd5; cfg_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check1("wr_cfg_ready", cfg_ready, 1'b1);
    check1("wr_en", ram_wr_en, 1'b1);
    check("wr_sel", 32'(ram_sel), 32'd2);
    check("wr_addr", 32'(ram_addr), 32'd5);
    check("wr_din", ram_din, 32'hDEADBEEF);
    nxt();
    cfg_valid = 1'b0;
    @(negedge clk);
    check1("wr_en_one_cycle", ram_wr_en, 1'b0);
    nxt();
    cfg_valid = 1'b1; cfg_we = 1'b0;
    @(negedge clk);
    check1("rd_accept", cfg_ready, 1'b1);
    nxt();
    cfg_valid = 1'b0;
    @(negedge clk);
    check1("rd_rvalid_cycle1", cfg_rvalid, 1'b0);
    nxt();
    @(negedge clk);
    check1("rd_rvalid_cycle2", cfg_rvalid, 1'b1);
    check("rd_data", cfg_rdata, 32'hDEADBEEF);
    nxt();
    @(negedge clk);
    check1("rd_rvalid_drop", cfg_rvalid, 1'b0);
    nxt();

    // Continuous lookups starve a host write until the forced grant.
    lk_valid = 1'b1; lk_sel = 8'd1; lk_addr = 4'd0;
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_sel = 8'd3; cfg_addr = 4'd7; cfg_wdata = 32'h1234_5678;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k < 9) begin
        check1("starve_lk_ready", lk_ready, 1'b1);
        check1("starve_wr_en", ram_wr_en, 1'b0);
        check1("starve_cfg_ready", cfg_ready, 1'b0);
      end else begin
        check1("force_lk_ready", lk_ready, 1'b0);
        check1("force_wr_en", ram_wr_en, 1'b1);
        check("force_sel", 32'(ram_sel), 32'd3);
      end
      nxt();
      lk_addr = lk_addr + 4'd1;
    end
    cfg_valid = 1'b0; lk_sel = 8'd3; lk_addr = 4'd7;
    @(negedge clk);
    check1("resume_lk_ready", lk_ready, 1'b1);
    nxt();
    @(negedge clk);
    check("lk_after_write", lk_rdata, 32'h1234_5678);
    lk_sel = 8'd1; lk_addr = 4'd3;
    nxt();
    lk_valid = 1'b0;
    nxt();

    // Readback held in RSP with rready low while lookups run.
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_sel = 8'd3; cfg_addr = 4'd7; cfg_rready = 1'b0;
    @(negedge clk);
    check1("rb_accept", cfg_ready, 1'b1);
    nxt();
    cfg_valid = 1'b0; lk_valid = 1'b1; lk_sel = 8'd0; lk_addr = 4'd2;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check1("rb_cfg_ready_low", cfg_ready, 1'b0);
      check1("rb_lk_ready", lk_ready, 1'b1);
      if (k >= 2) begin
        check1("rb_rvalid_held", cfg_rvalid, 1'b1);
        check("rb_rdata_stable", cfg_rdata, 32'h1234_5678);
      end
      nxt();
      lk_addr = lk_addr + 4'd3;
      if (k == 6) cfg_rready = 1'b1;
    end
    lk_valid = 1'b0;
    @(negedge clk);
    check1("rb_done_rvalid", cfg_rvalid, 1'b0);
    check1("rb_done_ready", cfg_ready, 1'b1);
    nxt();

    // Bad host select and bad lookup select.
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_sel = 8'd7; cfg_addr = 4'd5; cfg_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check1("bad_accept", cfg_ready, 1'b1);
    check1("bad_wr_en", ram_wr_en, 1'b0);
    nxt();
    cfg_valid = 1'b0;
    @(negedge clk);
    check1("bad_err_pulse", cfg_err, 1'b1);
    nxt();
    @(negedge clk);
    check1("bad_err_once", cfg_err, 1'b0);
    check1("bad_no_rvalid", cfg_rvalid, 1'b0);
    nxt();
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_sel = 8'd2; cfg_addr = 4'd5;
    @(negedge clk);
    nxt();
    cfg_valid = 1'b0; lk_valid = 1'b1; lk_sel = 8'd9; lk_addr = 4'd5;
    @(negedge clk);
    nxt();
    lk_valid = 1'b0;
    @(negedge clk);
    check("bad_ram_unchanged", cfg_rdata, 32'hDEADBEEF);
    check1("bad_lk_rvalid", lk_rvalid, 1'b1);
    check("bad_lk_rdata", lk_rdata, 32'h0);
    nxt();
    nxt();

    // Reset asserted while a response is pending in RSP.
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_sel = 8'd1; cfg_addr = 4'd4; cfg_rready = 1'b0;
    @(negedge clk);
    nxt();
    cfg_valid = 1'b0;
    @(negedge clk);
    nxt();
    @(negedge clk);
    check1("rsp_before_rst", cfg_rvalid, 1'b1);
    check("rsp_data", cfg_rdata, 32'hC0DE_0104);
    #1;
    rst = 1'b0;
    #1;
    check1("rst_drops_rvalid", cfg_rvalid, 1'b0);
    check("rst_clears_rdata", cfg_rdata, 32'h0);
    lk_q.delete(); cfg_q.delete(); err_q.delete();
    nxt();
    nxt();
    rst = 1'b1; cfg_rready = 1'b1;
    @(negedge clk);
    check1("post_rst_ready", cfg_ready, 1'b1);
    check1("post_rst_rvalid", cfg_rvalid, 1'b0);
    nxt();
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_sel = 8'd2; cfg_addr = 4'd5;
    @(negedge clk);
    nxt();
    cfg_valid = 1'b0;
    repeat (5) nxt();
    check("drain_lk", 32'(lk_q.size()), 32'd0);
    check("drain_cfg", 32'(cfg_q.size()), 32'd0);
    check("drain_err", 32'(err_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected $finish before 200000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/cfg_ram_ctrl.md
# cfg_ram_ctrl

Controller that shares the single address port of a bank of `NUM_RAM` `cfg_ram` instances between the parser's lookup path and the host configuration path. Lookups have priority and fixed one-cycle read latency. Host writes and readbacks are granted in idle slots, or forcibly after a starvation limit. It sits between the host config interface and the `cfg_ram` bank; all RAMs share its `ram_*` bus and decode `ram_sel` against their own `RAM_INDEX`.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: RAM address width.
- `DATA_WIDTH`, 32: RAM word width.
- `NUM_RAM`, 4: number of RAMs on the bus; valid selects are 0..NUM_RAM-1.
- `STARVE_LIMIT`, 8: consecutive blocked host cycles before the host is forcibly granted (≥1).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `lk_valid` / `lk_ready`  in / out  1  lookup request handshake.
- `lk_sel`  in  8  lookup RAM index.
- `lk_addr`  in  ADDR_WIDTH  lookup address.
- `lk_rvalid`  out  1  lookup data valid; no backpressure.
- `lk_rdata`  out  DATA_WIDTH  lookup data.
- `cfg_valid` / `cfg_ready`  in / out  1  host request handshake.
- `cfg_we`  in  1  1 = write, 0 = readback.
- `cfg_sel`  in  8  host RAM index.
- `cfg_addr`  in  ADDR_WIDTH  host address.
- `cfg_wdata`  in  DATA_WIDTH  host write data.
- `cfg_rvalid` / `cfg_rready`  out / in  1  readback response handshake.
- `cfg_rdata`  out  DATA_WIDTH  readback data.
- `cfg_err`  out  1  one-cycle pulse: accepted host request had `cfg_sel` ≥ NUM_RAM.
- `ram_addr`  out  ADDR_WIDTH  shared RAM address.
- `ram_sel`  out  8  shared RAM select.
- `ram_wr_en`  out  1  shared write enable.
- `ram_din`  out  DATA_WIDTH  shared write data.
- `ram_dout_bus`  in  NUM_RAM*DATA_WIDTH  RAM i output at bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- One grant per cycle. Priority is: forced host grant, then lookup, then host.
- `ram_*` outputs are driven combinationally from the granted request. With no grant: `ram_wr_en`=0, `ram_addr`=0, `ram_sel`=0, `ram_din`=0.
- `lk_ready` = ~force. A lookup is granted whenever `lk_valid` and not force.
- `cfg_ready` = (state==IDLE) & (~lk_valid | force).
- Host FSM states:
  - IDLE: an accepted write, or any request with a bad `cfg_sel`, stays in IDLE. An accepted valid read goes to RD_WAIT.
  - RD_WAIT: one cycle, then capture the selected RAM slice into `cfg_rdata` and go to RSP.
  - RSP: hold `cfg_rvalid`=1 and `cfg_rdata` until `cfg_rready`, then go to IDLE.
- Bad select (`cfg_sel` ≥ NUM_RAM):
  - Host: the request is consumed; `ram_wr_en`=0; `cfg_err` pulses; no response is issued.
  - Lookup: it is granted and returns `lk_rdata`=0 at the normal latency.
- Starvation counter, width $clog2(STARVE_LIMIT+1):
  - Increments when state==IDLE, `cfg_valid`=1 and `lk_valid`=1.
  - Clears on a host grant or when `cfg_valid`=0.
  - `force` = (counter==STARVE_LIMIT) & `cfg_valid` & state==IDLE.
- The RAMs are read-first. The write cycle's dout is ignored.

## Timing
- Lookup latency: `lk_rvalid` is a register set the cycle after a lookup grant. `lk_rdata` is the `ram_dout_bus` slice selected by the registered `lk_sel`, or 0 if that select is out of range.
- Readback latency: data appears 2 cycles after acceptance (`cfg_rvalid` high in RSP) and is held until `cfg_rready`.
- A host write is committed at the clock edge of acceptance, so a later readback of the same address returns the new data.
- A lookup granted in the cycle after a host write to the same address returns the new data.
- While in RD_WAIT or RSP, `cfg_ready`=0 and lookups proceed unimpeded. The counter does not count in these states.
- Reset values: state IDLE, counter 0, `lk_rvalid` 0, `cfg_rvalid` 0, `cfg_rdata` 0, `cfg_err` 0.
- Reset asserted mid-readback drops the pending response.

## Structure
- Package `cfg_ram_ctrl_pkg` holds:
  - the host FSM state enum (IDLE, RD_WAIT, RSP);
  - the `SEL_WIDTH`=8 constant;
  - the slice function for `ram_dout_bus`.
- Sub-module `cfg_ram_arb` holds the grant logic plus the starvation counter, and outputs `grant_lk`, `grant_cfg` and `force`.
- The readback FSM and the response registers stay in the top module.

## Test plan
- Host write sel=2 addr=5 data=0xDEADBEEF with no lookups: `ram_wr_en`=1 for one cycle with sel=2. A following readback returns 0xDEADBEEF with `cfg_rvalid` 2 cycles after acceptance.
- Lookups continuous on sel=1, host write pending, STARVE_LIMIT=8: `lk_ready` drops on exactly the 9th cycle, the host write is granted that cycle, and lookups resume the next cycle.
- Readback with `cfg_rready` held low for 5 cycles while lookups run: `cfg_rdata` stays stable, `cfg_ready`=0 throughout, and every lookup returns data 1 cycle after its grant.
- Host write with `cfg_sel`=7 (NUM_RAM=4): `cfg_err` pulses once, `ram_wr_en` stays 0, RAM contents are unchanged, and no `cfg_rvalid` is issued. A lookup with `lk_sel`=9 returns `lk_rdata`=0.
- Reset asserted during RSP: `cfg_rvalid`→0 immediately. After release, state is IDLE and `cfg_ready`=1 when no lookup is pending.
